// File: rtl/vfu_cmd_sequencer_if.sv
// CFU command/response channel between the VexRiscv CFU port and vfu_cmd_sequencer.
// master = CPU side, slave = sequencer side.
interface vfu_cmd_sequencer_if #(
  parameter int unsigned INSN_WIDTH     = 32,
  parameter int unsigned VEX_DATA_WIDTH = 32
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [INSN_WIDTH-1:0]     cmd_payload_instruction;
  logic [VEX_DATA_WIDTH-1:0] cmd_payload_inputs_0;
  logic [VEX_DATA_WIDTH-1:0] cmd_payload_inputs_1;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [VEX_DATA_WIDTH-1:0] rsp_payload_output;

  modport master (
    output cmd_valid, cmd_payload_instruction, cmd_payload_inputs_0, cmd_payload_inputs_1,
    output rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_output
  );

  modport slave (
    input  cmd_valid, cmd_payload_instruction, cmd_payload_inputs_0, cmd_payload_inputs_1,
    input  rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_output
  );
endinterface

// File: rtl/vfu_cmd_sequencer.sv
// In-order CFU command sequencer: FIFO-buffers commands, issues them to rvv_proc_main and
// returns one response per command after RSP_LATENCY cycles. Optional macro: VFU_SEQ_PERF_EN.
module vfu_cmd_sequencer #(
  parameter int unsigned INSN_WIDTH     = 32,
  parameter int unsigned VEX_DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RSP_LATENCY    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  vfu_cmd_sequencer_if.slave        cfu,
  output logic [INSN_WIDTH-1:0]     core_insn,
  output logic                      core_insn_valid,
  output logic [VEX_DATA_WIDTH-1:0] core_data_in_1,
  output logic [VEX_DATA_WIDTH-1:0] core_data_in_2,
  input  logic                      core_rdy,
  input  logic [VEX_DATA_WIDTH-1:0] core_data_out,
  output logic [31:0]               perf_issue_count,
  output logic [31:0]               perf_stall_count
);

  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LatW   = $clog2(RSP_LATENCY + 1);
  localparam int unsigned EntryW = INSN_WIDTH + 2 * VEX_DATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                    state_q, state_d;
  logic [LatW-1:0]           lat_cnt_q, lat_cnt_d;
  logic [EntryW-1:0]         mem_q [FIFO_DEPTH];
  logic [PtrW:0]             wr_ptr_q, rd_ptr_q;
  logic [EntryW-1:0]         entry_in, head, issue_src;
  logic [INSN_WIDTH-1:0]     core_insn_q;
  logic [VEX_DATA_WIDTH-1:0] core_data_1_q, core_data_2_q, payload_q;
  logic                      empty, full, push, pop, load_issue, capture;

  // Command FIFO
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign entry_in = {cfu.cmd_payload_instruction, cfu.cmd_payload_inputs_0,
                     cfu.cmd_payload_inputs_1};
  assign head     = mem_q[rd_ptr_q[PtrW-1:0]];

  assign cfu.cmd_ready = !full && !reset;
  assign push          = cfu.cmd_valid && cfu.cmd_ready;
  assign pop           = (state_q == StIssue);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= entry_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // The issue registers load on the edge into StIssue so the strobe and its operands appear
  // together; an entry being pushed into an empty FIFO is taken straight from the bus.
  assign issue_src = empty ? entry_in : head;

  always_comb begin
    state_d    = state_q;
    lat_cnt_d  = lat_cnt_q;
    load_issue = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (core_rdy && (!empty || push)) begin
          state_d    = StIssue;
          load_issue = 1'b1;
        end
      end
      StIssue: begin
        state_d   = StWait;
        lat_cnt_d = LatW'(RSP_LATENCY);
      end
      StWait: begin
        lat_cnt_d = lat_cnt_q - LatW'(1);
        if (lat_cnt_q == LatW'(1)) begin
          capture = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (cfu.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      lat_cnt_q     <= '0;
      core_insn_q   <= '0;
      core_data_1_q <= '0;
      core_data_2_q <= '0;
      payload_q     <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      if (load_issue) begin
        {core_insn_q, core_data_1_q, core_data_2_q} <= issue_src;
      end
      if (capture) payload_q <= core_data_out;
    end
  end

  assign core_insn              = core_insn_q;
  assign core_data_in_1         = core_data_1_q;
  assign core_data_in_2         = core_data_2_q;
  assign core_insn_valid        = (state_q == StIssue);
  assign cfu.rsp_valid          = (state_q == StResp);
  assign cfu.rsp_payload_output = payload_q;

`ifdef VFU_SEQ_PERF_EN
  logic [31:0] issue_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = (state_q == StIdle) && !empty && !core_rdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (state_q == StIssue) issue_cnt_q <= issue_cnt_q + 32'd1;
      if (stall)              stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_issue_count = issue_cnt_q;
  assign perf_stall_count = stall_cnt_q;
`else
  assign perf_issue_count = '0;
  assign perf_stall_count = '0;
`endif

endmodule

// File: tb/tb_vfu_cmd_sequencer.sv
// Self-checking bench for vfu_cmd_sequencer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based transaction model.
module tb_vfu_cmd_sequencer;
  localparam int IW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LAT   = 2;
`ifdef VFU_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [IW-1:0] insn;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } cmd_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          core_rdy;
  logic [DW-1:0] core_data_out;
  logic [IW-1:0] core_insn;
  logic          core_insn_valid;
  logic [DW-1:0] core_data_in_1, core_data_in_2;
  logic [31:0]   perf_issue_count, perf_stall_count;

  always #5 clk = ~clk;

  vfu_cmd_sequencer_if #(.INSN_WIDTH(IW), .VEX_DATA_WIDTH(DW)) cfu ();

  vfu_cmd_sequencer #(
    .INSN_WIDTH(IW), .VEX_DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .RSP_LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfu(cfu),
    .core_insn(core_insn),
    .core_insn_valid(core_insn_valid),
    .core_data_in_1(core_data_in_1),
    .core_data_in_2(core_data_in_2),
    .core_rdy(core_rdy),
    .core_data_out(core_data_out),
    .perf_issue_count(perf_issue_count),
    .perf_stall_count(perf_stall_count)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int dut_rsp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending commands in a queue, plus the age (cycles since issue) of the single
  // command in flight; -1 means nothing in flight.
  cmd_t        mq[$];
  int          phase = -1;
  bit          model_ok = 1'b0;
  cmd_t        last = '0;
  logic [DW-1:0] exp_payload = '0;
  logic [31:0] exp_issue = 0;
  logic [31:0] exp_stall = 0;

  always @(negedge clk) begin
    int   nphase;
    bit   had, push;
    cmd_t c;
    if (model_ok) begin
      check("cmd_ready", 64'(cfu.cmd_ready), 64'((mq.size() < DEPTH) && !reset));
      check("core_insn_valid", 64'(core_insn_valid), 64'(phase == 0));
      check("core_insn", 64'(core_insn), 64'(last.insn));
      check("core_data_in_1", 64'(core_data_in_1), 64'(last.a));
      check("core_data_in_2", 64'(core_data_in_2), 64'(last.b));
      check("rsp_valid", 64'(cfu.rsp_valid), 64'(phase == LAT + 1));
      check("rsp_payload", 64'(cfu.rsp_payload_output), 64'(exp_payload));
      check("perf_issue", 64'(perf_issue_count), PERF ? 64'(exp_issue) : 64'd0);
      check("perf_stall", 64'(perf_stall_count), PERF ? 64'(exp_stall) : 64'd0);
    end
    if (!reset && cfu.rsp_valid === 1'b1 && cfu.rsp_ready) dut_rsp++;
    if (reset) begin
      mq.delete();
      phase       = -1;
      last        = '0;
      exp_payload = '0;
      exp_issue   = 0;
      exp_stall   = 0;
      model_ok    = 1'b1;
    end else if (model_ok) begin
      nphase = phase;
      had    = (mq.size() > 0);
      push   = cfu.cmd_valid && (mq.size() < DEPTH);
      if (phase == 0) begin
        void'(mq.pop_front());
        exp_issue++;
        nphase = 1;
      end else if (phase >= 1 && phase <= LAT) begin
        if (phase == LAT) exp_payload = core_data_out;
        nphase = phase + 1;
      end else if (phase == LAT + 1) begin
        if (cfu.rsp_ready) nphase = -1;
      end
      if (push) begin
        c.insn = cfu.cmd_payload_instruction;
        c.a    = cfu.cmd_payload_inputs_0;
        c.b    = cfu.cmd_payload_inputs_1;
        mq.push_back(c);
      end
      if (phase == -1) begin
        if (core_rdy && mq.size() > 0) begin
          nphase = 0;
          last   = mq[0];
        end else if (had && !core_rdy) begin
          exp_stall++;
        end
      end
      phase = nphase;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [IW-1:0] i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    cfu.cmd_valid               = 1'b1;
    cfu.cmd_payload_instruction = i;
    cfu.cmd_payload_inputs_0    = a;
    cfu.cmd_payload_inputs_1    = b;
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    cfu.cmd_valid = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    cfu.cmd_valid = 1'b0;
    cfu.rsp_ready = 1'b1;
    core_rdy      = 1'b1;
    while ((phase != -1 || mq.size() != 0) && k < 200) begin
      cyc();
      k++;
    end
    check("drain_timeout", 64'(k < 200), 64'd1);
  endtask

  initial begin
    int base, k;
    cfu.cmd_valid               = 1'b0;
    cfu.cmd_payload_instruction = '0;
    cfu.cmd_payload_inputs_0    = '0;
    cfu.cmd_payload_inputs_1    = '0;
    cfu.rsp_ready               = 1'b1;
    core_rdy                    = 1'b1;
    core_data_out               = 32'hdead_0001;

    // Single command timeline
    do_reset();
    set_cmd(32'h0000_1057, 32'd5, 32'd7);
    @(negedge clk);
    check("rst_rsp_valid", 64'(cfu.rsp_valid), 64'd0);
    check("rst_insn_valid", 64'(core_insn_valid), 64'd0);
    check("rst_core_insn", 64'(core_insn), 64'd0);
    check("rst_cmd_ready", 64'(cfu.cmd_ready), 64'd1);
    cyc();
    cfu.cmd_valid = 1'b0;
    @(negedge clk);
    check("c1_insn_valid", 64'(core_insn_valid), 64'd1);
    check("c1_core_insn", 64'(core_insn), 64'h1057);
    check("c1_data_in_1", 64'(core_data_in_1), 64'd5);
    check("c1_data_in_2", 64'(core_data_in_2), 64'd7);
    cyc();
    core_data_out = 32'h1234;
    @(negedge clk);
    check("c2_insn_valid", 64'(core_insn_valid), 64'd0);
    cyc();
    @(negedge clk);
    check("c3_rsp_valid", 64'(cfu.rsp_valid), 64'd0);
    cyc();
    core_data_out = 32'hbeef_0002;
    @(negedge clk);
    check("c4_rsp_valid", 64'(cfu.rsp_valid), 64'd1);
    check("c4_rsp_payload", 64'(cfu.rsp_payload_output), 64'h1234);
    cyc();
    @(negedge clk);
    check("c5_rsp_valid", 64'(cfu.rsp_valid), 64'd0);
    cyc();

    // Three stall cycles, then release
    do_reset();
    core_rdy = 1'b0;
    set_cmd(32'h0000_2057, 32'd1, 32'd2);
    cyc();
    cfu.cmd_valid = 1'b0;
    cyc();
    cyc();
    cyc();
    core_rdy = 1'b1;
    @(negedge clk);
    check("stall_count", 64'(perf_stall_count), PERF ? 64'd3 : 64'd0);
    check("issue_before", 64'(perf_issue_count), 64'd0);
    cyc();
    @(negedge clk);
    check("stall_issue_strobe", 64'(core_insn_valid), 64'd1);
    cyc();
    @(negedge clk);
    check("issue_count", 64'(perf_issue_count), PERF ? 64'd1 : 64'd0);
    drain();

    // Fill the FIFO, push against a same-cycle pop, then hold the response
    do_reset();
    base          = dut_rsp;
    core_rdy      = 1'b0;
    cfu.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_cmd($urandom, $urandom, $urandom);
      cyc();
    end
    set_cmd(32'h0000_5057, 32'd55, 32'd66);
    core_rdy = 1'b1;
    @(negedge clk);
    check("full_refuse", 64'(cfu.cmd_ready), 64'd0);
    cyc();
    @(negedge clk);
    check("full_pop_refuse", 64'(cfu.cmd_ready), 64'd0);
    check("full_pop_issue", 64'(core_insn_valid), 64'd1);
    cyc();
    @(negedge clk);
    check("after_pop_accept", 64'(cfu.cmd_ready), 64'd1);
    cyc();
    cfu.cmd_valid = 1'b0;
    k = 0;
    while (phase != LAT + 1 && k < 20) begin
      cyc();
      k++;
    end
    check("resp_reach_timeout", 64'(k < 20), 64'd1);
    for (int i = 0; i < 10; i++) begin
      core_data_out = $urandom;
      @(negedge clk);
      check("hold_rsp_valid", 64'(cfu.rsp_valid), 64'd1);
      check("hold_no_issue", 64'(core_insn_valid), 64'd0);
      cyc();
    end
    drain();
    check("full_rsp_count", 64'(dut_rsp - base), 64'd5);

    // Reset while in WAIT with two queued entries
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_cmd($urandom, $urandom, $urandom);
      cyc();
    end
    cfu.cmd_valid = 1'b0;
    reset         = 1'b1;
    cyc();
    reset = 1'b0;
    base  = dut_rsp;
    @(negedge clk);
    check("mid_rst_cmd_ready", 64'(cfu.cmd_ready), 64'd1);
    check("mid_rst_rsp_valid", 64'(cfu.rsp_valid), 64'd0);
    for (int i = 0; i < 10; i++) begin
      cyc();
      @(negedge clk);
      check("mid_rst_no_issue", 64'(core_insn_valid), 64'd0);
    end
    check("mid_rst_no_rsp", 64'(dut_rsp - base), 64'd0);
    cyc();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cfu.cmd_valid               = 1'($urandom_range(0, 1));
      cfu.cmd_payload_instruction = $urandom;
      cfu.cmd_payload_inputs_0    = $urandom;
      cfu.cmd_payload_inputs_1    = $urandom;
      core_rdy                    = ($urandom_range(0, 3) != 0);
      cfu.rsp_ready               = ($urandom_range(0, 2) != 0);
      core_data_out               = $urandom;
      reset                       = ($urandom_range(0, 249) == 0);
      cyc();
    end
    reset = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
